// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] FETCH_WORD_BYTES       = 32'd4;
  localparam logic [31:0] FETCH_RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_addr_sel.sv
// Issue-address and next-sequential-address selection for fetch_unit.
// Define BRANCH_DELAY_SLOT_EN for MIPS delay-slot semantics on redirects.
module fetch_addr_sel
  import fetch_pkg::*;
(
  input  fetch_state_t state,
  input  logic         handshake,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  input  logic [31:0]  next_addr,
  output logic         issue_req,
  output logic [31:0]  issue_addr,
  output logic [31:0]  next_addr_nxt
);

  logic [31:0] target;

  always_comb begin
    target        = {redirect_pc[31:2], 2'b00};
    issue_req     = 1'b0;
    issue_addr    = '0;
    next_addr_nxt = next_addr;
    if (state == FETCH) begin
      issue_req     = 1'b1;
      issue_addr    = next_addr;
      next_addr_nxt = next_addr + FETCH_WORD_BYTES;
    end else if (state == HOLD && handshake) begin
      issue_req = 1'b1;
      if (redirect_valid) begin
`ifdef BRANCH_DELAY_SLOT_EN
        // next_addr is the delay slot; the target is fetched right after it
        issue_addr    = next_addr;
        next_addr_nxt = target;
`else
        issue_addr    = target;
        next_addr_nxt = target + FETCH_WORD_BYTES;
`endif
      end else begin
        issue_addr    = next_addr;
        next_addr_nxt = next_addr + FETCH_WORD_BYTES;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC register, one-outstanding imem reads,
// valid/ready delivery to decode, and redirect handling.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  fetch_state_t state_q, state_d;
  logic [31:0]  next_addr_q, next_addr_d;
  logic [31:0]  inflight_pc_q, inflight_pc_d;
  logic         out_valid_q, out_valid_d;
  logic [31:0]  out_instr_q, out_instr_d;
  logic [31:0]  out_pc_q, out_pc_d;

  logic         handshake;
  logic         issue_req;
  logic [31:0]  issue_addr;
  logic [31:0]  sel_next_addr;

  assign handshake = (state_q == HOLD) && out_ready;

  fetch_addr_sel u_addr_sel (
    .state          (state_q),
    .handshake      (handshake),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .next_addr      (next_addr_q),
    .issue_req      (issue_req),
    .issue_addr     (issue_addr),
    .next_addr_nxt  (sel_next_addr)
  );

  always_comb begin
    state_d       = state_q;
    next_addr_d   = next_addr_q;
    inflight_pc_d = inflight_pc_q;
    out_valid_d   = out_valid_q;
    out_instr_d   = out_instr_q;
    out_pc_d      = out_pc_q;

    if (issue_req) begin
      next_addr_d   = sel_next_addr;
      inflight_pc_d = issue_addr;
    end

    case (state_q)
      BOOT:  state_d = FETCH;
      FETCH: state_d = WAIT;
      WAIT: begin
        if (imem_rvalid) begin
          out_instr_d = imem_rdata;
          out_pc_d    = inflight_pc_q;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = WAIT;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      next_addr_q   <= RESET_PC;
      inflight_pc_q <= '0;
      out_valid_q   <= 1'b0;
      out_instr_q   <= '0;
      out_pc_q      <= '0;
    end else begin
      state_q       <= state_d;
      next_addr_q   <= next_addr_d;
      inflight_pc_q <= inflight_pc_d;
      out_valid_q   <= out_valid_d;
      out_instr_q   <= out_instr_d;
      out_pc_q      <= out_pc_d;
    end
  end

  assign imem_req  = issue_req;
  assign imem_addr = issue_addr;
  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_pc    = out_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: variable-latency memory model and a
// pc/npc reference model of the delivered instruction stream.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Instruction memory: one response per request, 'lat' cycles later.
  int unsigned lat = 1;
  logic        pend;
  logic [31:0] pend_addr;
  int unsigned pend_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_rvalid <= 1'b0;
      imem_rdata  <= '0;
      pend        <= 1'b0;
      pend_addr   <= '0;
      pend_cnt    <= 0;
    end else begin
      imem_rvalid <= 1'b0;
      if (pend) begin
        if (pend_cnt == 1) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= memf(pend_addr);
          pend        <= 1'b0;
        end else begin
          pend_cnt <= pend_cnt - 1;
        end
      end
      if (imem_req) begin
        if (lat <= 1) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= memf(imem_addr);
        end else begin
          pend      <= 1'b1;
          pend_addr <= imem_addr;
          pend_cnt  <= lat - 1;
        end
      end
    end
  end

  // Reference model: pc = next instruction to deliver, npc = one after it.
  logic        mvalid;
  logic [31:0] m_pc;
  logic [31:0] m_npc;
  int unsigned since_rel;
  logic [31:0] log_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mvalid    = 1'b0;
    m_pc      = RESET_PC;
    m_npc     = RESET_PC + 32'd4;
    since_rel = 0;
  endtask

  task automatic model_advance(input logic rv, input logic [31:0] rpc);
    logic [31:0] tgt;
    tgt = rpc & 32'hFFFF_FFFC;
`ifdef BRANCH_DELAY_SLOT_EN
    m_pc  = m_npc;
    m_npc = rv ? tgt : m_npc + 32'd4;
`else
    m_pc  = rv ? tgt : m_pc + 32'd4;
`endif
  endtask

  task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
    logic hs;
    logic exp_req;
    @(posedge clk);
    #1;
    since_rel++;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, mvalid});
    if (mvalid) begin
      chk("out_pc", out_pc, m_pc);
      chk("out_instr", out_instr, memf(m_pc));
    end
    hs = mvalid && rdy;
    if (hs) begin
      log_q.push_back(m_pc);
      model_advance(rv, rpc);
    end
    exp_req = hs || (since_rel == 1);
    chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    mvalid = imem_rvalid || (mvalid && !hs);
  endtask

  task automatic deliver(input logic rv, input logic [31:0] rpc);
    int unsigned n;
    n = 0;
    while (!mvalid && n < 20) begin
      step(1'b1, 1'b0, 32'h0);
      n++;
    end
    chk("deliver_timeout", {31'd0, mvalid}, 32'd1);
    if (mvalid) step(1'b1, rv, rpc);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_instr"}, out_instr, 32'd0);
    chk({tag, "_pc"}, out_pc, 32'd0);
    chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    chk({tag, "_addr"}, imem_addr, 32'd0);
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    #1;
    check_zero_outputs("rst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    #1;
    check_zero_outputs("boot");
  endtask

  initial begin
    rst_n          = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    model_reset();
    #2;

    // Sequential fetch, 1-cycle memory, ready held high
    lat = 1;
    do_reset();
    log_q.delete();
    repeat (3) deliver(1'b0, 32'h0);
    chk("seq0", log_q[0], 32'h0);
    chk("seq1", log_q[1], 32'h4);
    chk("seq2", log_q[2], 32'h8);

    // Back-pressure with an ignored redirect pulse
    deliver(1'b0, 32'h0);
    while (!mvalid) step(1'b0, 1'b0, 32'h0);
    repeat (2) step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h0000_0080);
    repeat (2) step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);

    // Branch at 0x10 to 0x40
    do_reset();
    repeat (4) deliver(1'b0, 32'h0);
    log_q.delete();
    deliver(1'b1, 32'h0000_0040);
    repeat (3) deliver(1'b0, 32'h0);
`ifdef BRANCH_DELAY_SLOT_EN
    chk("br0", log_q[0], 32'h10);
    chk("br1", log_q[1], 32'h14);
    chk("br2", log_q[2], 32'h40);
    chk("br3", log_q[3], 32'h44);
`else
    chk("br0", log_q[0], 32'h10);
    chk("br1", log_q[1], 32'h40);
    chk("br2", log_q[2], 32'h44);
    chk("br3", log_q[3], 32'h48);
`endif

    // Wrap-around via an unaligned redirect target
    lat = 2;
    do_reset();
    log_q.delete();
    deliver(1'b1, 32'hFFFF_FFFE);
    repeat (3) deliver(1'b0, 32'h0);
`ifdef BRANCH_DELAY_SLOT_EN
    chk("wrap1", log_q[1], 32'h4);
    chk("wrap2", log_q[2], 32'hFFFF_FFFC);
    chk("wrap3", log_q[3], 32'h0);
`else
    chk("wrap1", log_q[1], 32'hFFFF_FFFC);
    chk("wrap2", log_q[2], 32'h0);
`endif

    // Reset while a 3-cycle response is outstanding
    lat = 3;
    do_reset();
    deliver(1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    do_reset();
    log_q.delete();
    repeat (2) deliver(1'b0, 32'h0);
    chk("rst_restart", log_q[0], RESET_PC);

    // Randomized traffic
    for (int unsigned seg = 0; seg < 4; seg++) begin
      lat = $urandom_range(1, 3);
      do_reset();
      for (int unsigned c = 0; c < 80; c++) begin
        step(($urandom % 4) != 0, ($urandom % 5) == 0,
             (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
